// File: rtl/prn_code_gen_if.sv
// prn_code_gen_if: seed-load handshake and chip stream bundle for prn_code_gen
interface prn_code_gen_if #(parameter int IW = 14);
  logic load_start;
  logic seed_valid;
  logic seed_bit;
  logic seed_ready;
  logic chip_en;
  logic chip_out;
  logic chip_valid;
  logic [IW-1:0] chip_idx;
  logic epoch;
  logic busy;
  modport master (output load_start, seed_valid, seed_bit, chip_en,
                  input seed_ready, chip_out, chip_valid, chip_idx, epoch, busy);
  modport slave (input load_start, seed_valid, seed_bit, chip_en,
                 output seed_ready, chip_out, chip_valid, chip_idx, epoch, busy);
endinterface

// File: rtl/prn_code_gen.sv
// prn_code_gen: parametrised coupled-LFSR PRN generator with serial seed load and periodic re-seed
// Define PRN_BOC_EN for BOC(1,1) output (each chip spans two chip_en strobes, second half inverted).
module prn_code_gen #(
  parameter int LFSR_W = 55,
  parameter int RF_W = 5,
  parameter logic [LFSR_W-1:0] TAPS_A = 55'h40000000000021,
  parameter logic [LFSR_W-1:0] TAPS_B = 55'h40000000008003,
  parameter logic [LFSR_W-1:0] CPL_MASK = 55'h00000000000105,
  parameter int CODE_LEN = 10230
) (
  input logic clk,
  input logic rst,
  prn_code_gen_if.slave bus
);
  localparam int IW = $clog2(CODE_LEN);
  localparam int N = 2 * LFSR_W + RF_W;
  localparam int LW = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_d;
  logic [LFSR_W-1:0] r0, r1;
  logic [RF_W-1:0] rf;
  logic [N-1:0] snap, chain, shifted, seeded, nxt;
  logic [2*RF_W-1:0] rr;
  logic [LW-1:0] lcnt;
  logic [IW-1:0] cnt;
  logic accept, last_bit, emit, step, wrap, fa, fb, c, hf;
  // bit 1 of the popcount is the second elementary symmetric function mod 2
  function automatic logic sigma2(input logic [LFSR_W-1:0] v);
    logic [1:0] a;
    a = '0;
    for (int i = 0; i < LFSR_W; i++) a = a + 2'(v[i]);
    return a[1];
  endfunction
  always_comb begin
    accept = state == LOAD && bus.seed_valid && !bus.load_start;
    last_bit = accept && lcnt == LW'(N - 1);
    emit = state == RUN && bus.chip_en && !bus.load_start;
    wrap = cnt == IW'(CODE_LEN - 1);
    chain = {r0, r1, rf};
    shifted = {chain[N-2:0], bus.seed_bit};
    seeded = shifted | ((shifted[N-1 -: LFSR_W] == '0) ? (N'(1) << (N - LFSR_W)) : '0);
    fa = ^(r0 & TAPS_A);
    fb = ^(r1 & TAPS_B) ^ (^(r0 & CPL_MASK) & sigma2(r0 & TAPS_A));
    rr = {rf, rf} >> (RF_W - 1);
    c = r0[LFSR_W-1] ^ r1[LFSR_W-1] ^ rf[RF_W-1];
    nxt = wrap ? snap : {r0[LFSR_W-2:0], fa, r1[LFSR_W-2:0], fb, rr[RF_W-1:0]};
    state_d = bus.load_start ? LOAD : last_bit ? RUN : state;
  end
`ifdef PRN_BOC_EN
  always_ff @(posedge clk)
    if (rst || bus.load_start) hf <= 1'b0;
    else if (emit) hf <= !hf;
  assign step = emit && hf;
`else
  assign hf = 1'b0;
  assign step = emit;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk)
    if (rst) begin
      {r0, r1, rf} <= '0;
      snap <= '0;
      lcnt <= '0;
      cnt <= '0;
      bus.chip_out <= 1'b0;
      bus.chip_valid <= 1'b0;
      bus.chip_idx <= '0;
      bus.epoch <= 1'b0;
    end else begin
      bus.chip_valid <= emit;
      bus.epoch <= emit && wrap;
      if (bus.load_start) begin
        lcnt <= '0;
        cnt <= '0;
      end
      if (accept) begin
        lcnt <= lcnt + 1'b1;
        {r0, r1, rf} <= last_bit ? seeded : shifted;
        if (last_bit) snap <= seeded;
      end
      if (emit) begin
        bus.chip_out <= c ^ hf;
        bus.chip_idx <= cnt;
      end
      if (step) begin
        {r0, r1, rf} <= nxt;
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
    end
  assign bus.seed_ready = state == LOAD;
  assign bus.busy = state != IDLE;
endmodule
